main_fsm: RTL and testbench
===========================

MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, meaning max memory wait cycles before timeout (used only with MAIN_FSM_MEMWAIT_EN).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port Op  input  2  instruction op field.
REQ-005 SHALL have port Funct  input  6  instruction funct field; bit5 = I, bit0 = S/L.
REQ-006 SHALL have port mem_ready  input  1  memory access complete.
REQ-007 SHALL have outputs IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  output  1 each  datapath/condlogic controls.
REQ-008 SHALL have outputs ALUSrcA  output  1; ALUSrcB, ResultSrc  output  2 each  mux selects.
REQ-009 SHALL have outputs mem_timeout, illegal_op  output  1 each  single-cycle error pulses; state_o  output  4  current state encoding.

Function
REQ-010 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH; all controls decoded from state only, except mem_ready gating per REQ-016.
REQ-011 SHALL decode outputs (unlisted = 0): FETCH AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=1, NextPC=1; DECODE ALUSrcA=1, ALUSrcB=10, ResultSrc=10; MEMADR ALUSrcB=01; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegW=1; MEMWRITE AdrSrc=1, MemW=1; EXECUTER ALUOp=1; EXECUTEI ALUSrcB=01, ALUOp=1; ALUWB RegW=1; BRANCH ALUSrcB=01, ResultSrc=10, Branch=1.
REQ-012 SHALL transition FETCH->DECODE; DECODE: Op=00,Funct[5]=0->EXECUTER; Op=00,Funct[5]=1->EXECUTEI; Op=01->MEMADR; Op=10->BRANCH; Op=11->FETCH.
REQ-013 SHALL pulse illegal_op for one cycle on DECODE->FETCH via Op=11.
REQ-014 SHALL transition MEMADR->MEMREAD if Funct[0]=1 else MEMWRITE; MEMREAD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-015 SHALL spend exactly one cycle per state when no wait is in progress; ADD reg = 4 cycles, LDR = 5, STR = 4, B = 3.
REQ-016 SHALL, in wait mode, hold FETCH/MEMREAD/MEMWRITE until mem_ready=1; IRWrite and NextPC asserted only in the FETCH cycle with mem_ready=1; MemW held for the whole MEMWRITE stay.
REQ-017 SHALL count wait cycles (mem_ready=0) in a waiting state; on count reaching WAIT_MAX, pulse mem_timeout one cycle and go to FETCH; counter cleared on every state change.
REQ-018 SHALL treat mem_ready=1 in the same cycle the count reaches WAIT_MAX as success (no timeout).
REQ-019 SHALL map an unreachable state_o encoding to FETCH on the next edge.

Reset
REQ-020 SHALL, on reset=0, asynchronously force state FETCH, wait counter 0, mem_timeout=0, illegal_op=0; outputs then show FETCH decode.
REQ-021 SHALL abandon any in-progress instruction or wait on mid-operation reset, resuming at FETCH on the first edge after reset=1.

Configuration
REQ-022 SHALL, with MAIN_FSM_MEMWAIT_EN defined, implement REQ-016 to REQ-018.
REQ-023 SHALL, without MAIN_FSM_MEMWAIT_EN, ignore mem_ready (treated as 1), omit the counter, and tie mem_timeout to 0.

Structure
REQ-024 SHALL take the state enum (statetype, 4-bit) and ALUSrcB/ResultSrc select constants from shared package arm_ctrl_pkg.
REQ-025 SHALL place the wait counter in sub-module memwait_ctr, instantiated only under MAIN_FSM_MEMWAIT_EN.

Verification
REQ-026 SHALL cover: reset=0 mid-MEMREAD -> state_o=FETCH immediately, IRWrite=1, counter 0.
REQ-027 SHALL cover: Op=01, Funct[0]=1, mem_ready=1 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegW=1 only in MEMWB, ResultSrc=01.
REQ-028 SHALL cover: Op=00, Funct[5]=1 -> EXECUTEI with ALUSrcB=01, ALUOp=1, then ALUWB RegW=1, back to FETCH in 4 cycles.
REQ-029 SHALL cover: Op=11 -> DECODE->FETCH with illegal_op=1 for one cycle, no RegW/MemW.
REQ-030 SHALL cover (MAIN_FSM_MEMWAIT_EN): mem_ready=0 in FETCH for 3 cycles then 1 -> NextPC/IRWrite high once; mem_ready=0 for 15 cycles -> mem_timeout pulse, state FETCH.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared multicycle-controller state encoding, mux-select constants and per-state control decode
package arm_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
    } statetype;
    localparam logic [1:0] SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_DATA = 2'b01, RES_ALU = 2'b10;
    typedef struct packed {
        logic irwrite, adrsrc, nextpc, regw, memw, branch, aluop, alusrca;
        logic [1:0] alusrcb, resultsrc;
    } ctrl_t;
    function automatic ctrl_t decode(statetype s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    begin c.irwrite = 1'b1; c.nextpc = 1'b1; c.alusrca = 1'b1; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALU; end
            DECODE:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_FOUR; c.resultsrc = RES_ALU; end
            MEMADR:   c.alusrcb = SRCB_IMM;
            MEMREAD:  c.adrsrc = 1'b1;
            MEMWB:    begin c.resultsrc = RES_DATA; c.regw = 1'b1; end
            MEMWRITE: begin c.adrsrc = 1'b1; c.memw = 1'b1; end
            EXECUTER: c.aluop = 1'b1;
            EXECUTEI: begin c.alusrcb = SRCB_IMM; c.aluop = 1'b1; end
            ALUWB:    c.regw = 1'b1;
            BRANCH:   begin c.alusrcb = SRCB_IMM; c.resultsrc = RES_ALU; c.branch = 1'b1; end
            default:  c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/memwait_ctr.sv
// memwait_ctr: counts memory-wait cycles and flags the cycle whose wait would reach WAIT_MAX
module memwait_ctr #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic mem_ready,
    output logic hit
);
    localparam int W = $clog2(WAIT_MAX + 1);
    logic [W-1:0] cnt;
    assign hit = waiting && !mem_ready && cnt == W'(WAIT_MAX - 1);
    // any exit from the wait (ready, timeout, or not waiting) restarts the count
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else cnt <= (!waiting || mem_ready || hit) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/main_fsm.sv
// main_fsm: multicycle ARM main controller (Moore FSM).
// Define MAIN_FSM_MEMWAIT_EN to add mem_ready handshaking with WAIT_MAX timeout.
module main_fsm
    import arm_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       mem_timeout,
    output logic       illegal_op,
    output logic [3:0] state_o
);
    statetype state, next;
    logic ready, hit, waiting;
    ctrl_t c;
    assign waiting = state inside {FETCH, MEMREAD, MEMWRITE};
`ifdef MAIN_FSM_MEMWAIT_EN
    assign ready = mem_ready;
    memwait_ctr #(.WAIT_MAX(WAIT_MAX)) u_ctr (
        .clk(clk), .reset(reset), .waiting(waiting), .mem_ready(mem_ready), .hit(hit)
    );
`else
    logic unused;
    assign ready = 1'b1;
    assign hit = 1'b0;
    assign unused = mem_ready ^ waiting ^ (WAIT_MAX == 0);
`endif
    always_comb begin
        next = FETCH;
        case (state)
            FETCH:              next = ready ? DECODE : FETCH;
            DECODE:             next = Op == 2'b00 ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                       Op == 2'b01 ? MEMADR : Op == 2'b10 ? BRANCH : FETCH;
            MEMADR:             next = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:            next = ready ? MEMWB : hit ? FETCH : MEMREAD;
            MEMWRITE:           next = (ready || hit) ? FETCH : MEMWRITE;
            EXECUTER, EXECUTEI: next = ALUWB;
            default:            next = FETCH;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= FETCH;
            mem_timeout <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state <= next;
            mem_timeout <= hit;
            illegal_op <= state == DECODE && Op == 2'b11;
        end
    assign c = decode(state);
    assign IRWrite = c.irwrite & ready;
    assign NextPC = c.nextpc & ready;
    assign {AdrSrc, RegW, MemW, Branch, ALUOp, ALUSrcA} = {c.adrsrc, c.regw, c.memw, c.branch, c.aluop, c.alusrca};
    assign ALUSrcB = c.alusrcb;
    assign ResultSrc = c.resultsrc;
    assign state_o = state;
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed stimulus, per-cycle behavioural model compare plus literal expectations
module tb_main_fsm;
    import arm_ctrl_pkg::*;
    localparam int WAIT_MAX = 15;
    logic clk = 0, reset, mem_ready;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, ALUSrcA, mem_timeout, illegal_op;
    logic [1:0] ALUSrcB, ResultSrc;
    logic [3:0] state_o;
    logic [11:0] ctrls;
    logic rdy;
    int n_chk = 0, n_fail = 0;

    main_fsm #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .Branch(Branch), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .mem_timeout(mem_timeout), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;
    assign ctrls = {IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, ALUSrcA, ALUSrcB, ResultSrc};
`ifdef MAIN_FSM_MEMWAIT_EN
    assign rdy = mem_ready;
`else
    assign rdy = 1'b1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {IRWrite,AdrSrc,NextPC,RegW,MemW,Branch,ALUOp,ALUSrcA,ALUSrcB,ResultSrc}
    function automatic logic [11:0] exp_ctrl(statetype s, logic r);
        case (s)
            FETCH:    return {r, 1'b0, r, 9'b0000_1_1010};
            DECODE:   return 12'b000_0000_1_1010;
            MEMADR:   return 12'b000_0000_0_0100;
            MEMREAD:  return 12'b010_0000_0_0000;
            MEMWB:    return 12'b000_1000_0_0001;
            MEMWRITE: return 12'b010_0100_0_0000;
            EXECUTER: return 12'b000_0001_0_0000;
            EXECUTEI: return 12'b000_0001_0_0100;
            ALUWB:    return 12'b000_1000_0_0000;
            BRANCH:   return 12'b000_0010_0_0110;
            default:  return 12'hfff;
        endcase
    endfunction

    // model: an instruction is a list of phases planned at decode, memory phases may stall
    statetype m_st = FETCH;
    statetype path[$];
    int waits = 0;
    bit m_ill = 0, m_to = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = FETCH; path.delete(); waits = 0; m_ill = 0; m_to = 0;
        end else begin
            m_ill = 0; m_to = 0;
            if (m_st inside {FETCH, MEMREAD, MEMWRITE} && !rdy) begin
                waits++;
                if (waits == WAIT_MAX) begin
                    m_to = 1; waits = 0; path.delete(); m_st = FETCH;
                end
            end else begin
                waits = 0;
                if (m_st == FETCH) m_st = DECODE;
                else begin
                    if (m_st == DECODE) begin
                        if (Op == 2'b00) begin
                            path.push_back(Funct[5] ? EXECUTEI : EXECUTER);
                            path.push_back(ALUWB);
                        end else if (Op == 2'b01) begin
                            path.push_back(MEMADR);
                            path.push_back(Funct[0] ? MEMREAD : MEMWRITE);
                            if (Funct[0]) path.push_back(MEMWB);
                        end else if (Op == 2'b10) path.push_back(BRANCH);
                        else m_ill = 1;
                    end
                    m_st = path.size() > 0 ? path.pop_front() : FETCH;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_state", state_o, m_st);
        chk("model_ctrl", ctrls, exp_ctrl(m_st, rdy));
        chk("model_timeout", mem_timeout, m_to);
        chk("model_illegal", illegal_op, m_ill);
    end

    task automatic step(input statetype e);
        @(negedge clk);
        chk("seq_state", state_o, e);
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] f);
        #1 Op = op; Funct = f;
    endtask

    initial begin
        reset = 0; Op = 0; Funct = 0; mem_ready = 1;
        @(negedge clk);
        chk("rst_state", state_o, FETCH);
        chk("rst_irwrite", IRWrite, 1);
        chk("rst_nextpc", NextPC, 1);
        chk("rst_pulses", {mem_timeout, illegal_op}, 0);
        #1 reset = 1;
        // LDR
        instr(2'b01, 6'b000001);
        step(DECODE); step(MEMADR); step(MEMREAD);
        chk("ldr_memread_regw", RegW, 0);
        step(MEMWB);
        chk("ldr_memwb_regw", RegW, 1);
        chk("ldr_memwb_res", ResultSrc, 2'b01);
        step(FETCH);
        // ADD immediate
        instr(2'b00, 6'b100000);
        step(DECODE); step(EXECUTEI);
        chk("addi_srcb", ALUSrcB, 2'b01);
        chk("addi_aluop", ALUOp, 1);
        step(ALUWB);
        chk("addi_regw", RegW, 1);
        step(FETCH);
        // ADD register
        instr(2'b00, 6'b000000);
        step(DECODE); step(EXECUTER); step(ALUWB); step(FETCH);
        // STR
        instr(2'b01, 6'b000000);
        step(DECODE); step(MEMADR); step(MEMWRITE);
        chk("str_memw", MemW, 1);
        chk("str_adrsrc", AdrSrc, 1);
        step(FETCH);
        // B
        instr(2'b10, 6'b000000);
        step(DECODE); step(BRANCH);
        chk("b_branch", Branch, 1);
        step(FETCH);
        // illegal op
        instr(2'b11, 6'b000000);
        step(DECODE); step(FETCH);
        chk("ill_pulse", illegal_op, 1);
        chk("ill_no_write", {RegW, MemW}, 0);
        instr(2'b10, 6'b000000);
        step(DECODE);
        chk("ill_pulse_end", illegal_op, 0);
        step(BRANCH); step(FETCH);
`ifndef MAIN_FSM_MEMWAIT_EN
        instr(2'b00, 6'b000000);
        mem_ready = 0;
        step(DECODE); step(EXECUTER); step(ALUWB); step(FETCH);
        chk("nowait_timeout", mem_timeout, 0);
        #1 mem_ready = 1;
`endif
        // async reset mid-MEMREAD
        instr(2'b01, 6'b000001);
        step(DECODE); step(MEMADR); step(MEMREAD);
        #2 reset = 0;
        #1 chk("arst_state", state_o, FETCH);
        chk("arst_irwrite", IRWrite, 1);
        step(FETCH);
        #1 reset = 1;
        step(DECODE); step(MEMADR); step(MEMREAD); step(MEMWB); step(FETCH);
`ifdef MAIN_FSM_MEMWAIT_EN
        // fetch stall 3 cycles
        instr(2'b00, 6'b000000);
        mem_ready = 0;
        repeat (3) begin
            step(FETCH);
            chk("stall_irwrite", {IRWrite, NextPC}, 0);
        end
        #1 mem_ready = 1;
        #1 chk("stall_release", {IRWrite, NextPC}, 2'b11);
        step(DECODE); step(EXECUTER); step(ALUWB); step(FETCH);
        // fetch timeout after WAIT_MAX stalled cycles
        #1 mem_ready = 0;
        repeat (14) begin
            step(FETCH);
            chk("to_early", mem_timeout, 0);
        end
        step(FETCH);
        chk("to_pulse", mem_timeout, 1);
        step(FETCH);
        chk("to_pulse_end", mem_timeout, 0);
        #1 mem_ready = 1;
        step(DECODE); step(EXECUTER); step(ALUWB); step(FETCH);
        // ready arriving on the WAIT_MAX-th cycle wins
        #1 mem_ready = 0;
        repeat (14) step(FETCH);
        #1 mem_ready = 1;
        step(DECODE);
        chk("edge_no_timeout", mem_timeout, 0);
        step(EXECUTER); step(ALUWB); step(FETCH);
        // MEMREAD timeout
        instr(2'b01, 6'b000001);
        step(DECODE); step(MEMADR);
        #1 mem_ready = 0;
        step(MEMREAD);
        repeat (14) step(MEMREAD);
        step(FETCH);
        chk("rd_to_pulse", mem_timeout, 1);
        #1 mem_ready = 1;
        // STR stall keeps MemW
        instr(2'b01, 6'b000000);
        step(DECODE); step(MEMADR);
        #1 mem_ready = 0;
        step(MEMWRITE); step(MEMWRITE);
        chk("wr_hold_memw", MemW, 1);
        #1 mem_ready = 1;
        step(FETCH);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
